// File: rtl/register_file_pkg.sv
// Shared datapath sizing for the register file, decode and ALU.
// It also holds the register word type and the reset value.
package register_file_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam data_t DATA_ZERO = {DATA_WIDTH{1'b0}};

endpackage

// File: rtl/register_file_if.sv
// Register file access bus: one write port and two read ports.
// Decode and writeback drive the master side. The register file is the slave.
interface register_file_if;
  import register_file_pkg::*;

  logic  write_enable;
  addr_t write_reg;
  data_t write_data;
  addr_t read_reg1;
  addr_t read_reg2;
  data_t read_data1;
  data_t read_data2;

  modport master (
    output write_enable, write_reg, write_data, read_reg1, read_reg2,
    input  read_data1, read_data2
  );

  modport slave (
    input  write_enable, write_reg, write_data, read_reg1, read_reg2,
    output read_data1, read_data2
  );

endinterface

// File: rtl/register_file_read_port.sv
// Combinational read mux that selects one register word by its address.
// No bypass is applied, so a same-cycle write shows up only after the clock edge.
module register_file_read_port
  import register_file_pkg::*;
(
  input  data_t regs_i [NUM_REGS],
  input  addr_t addr_i,
  output data_t data_o
);

  assign data_o = regs_i[addr_i];

endmodule

// File: rtl/register_file.sv
// An 8 x 8 general-purpose register file with two asynchronous read ports and one write port.
// Reset is synchronous and takes priority over a write on the same edge. Register 0 can be written.
module register_file
  import register_file_pkg::*;
(
  input logic           clk,
  input logic           reset,
  register_file_if.slave bus
);

  data_t regs_q [NUM_REGS];
  data_t regs_d [NUM_REGS];

  // Next-state logic: apply the write when it is enabled.
  always_comb begin
    regs_d = regs_q;
    if (bus.write_enable) begin
      regs_d[bus.write_reg] = bus.write_data;
    end else begin
      regs_d = regs_q;
    end
  end

  // State register: reset clears every register and overrides any write on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_ZERO;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  register_file_read_port u_read_port1 (
    .regs_i (regs_q),
    .addr_i (bus.read_reg1),
    .data_o (bus.read_data1)
  );

  register_file_read_port u_read_port2 (
    .regs_i (regs_q),
    .addr_i (bus.read_reg2),
    .data_o (bus.read_data2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file that runs directed cases and then randomized traffic.
// Results are compared against an array-based model of the register contents.
module tb_register_file;
  import register_file_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   model [NUM_REGS];

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_WIDTH-1:0] obs,
                     input logic [DATA_WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one rising edge, update the reference model, and return 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = 0;
    end else if (bus.write_enable) begin
      model[bus.write_reg] = int'(bus.write_data);
    end
    #1;
  endtask

  task automatic rd(input int a1, input int a2);
    bus.read_reg1 = addr_t'(a1);
    bus.read_reg2 = addr_t'(a2);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    bus.write_enable = 1'b1;
    bus.write_reg    = addr_t'(a);
    bus.write_data   = data_t'(d);
    step();
    bus.write_enable = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = -1;
    reset            = 1'b1;
    bus.write_enable = 1'b0;
    bus.write_reg    = 3'd0;
    bus.write_data   = 8'd0;
    bus.read_reg1    = 3'd0;
    bus.read_reg2    = 3'd0;
    @(negedge clk);
    step();
    reset = 1'b0;

    // 1. Reset clears every register.
    for (int a = 0; a < NUM_REGS; a++) begin
      rd(a, NUM_REGS - 1 - a);
      chk("reset_rd1", bus.read_data1, 8'd0);
      chk("reset_rd2", bus.read_data2, 8'd0);
    end

    // 2. Write two registers and read them back. Register 0 is writable.
    wr(0, 13);
    wr(1, 25);
    rd(0, 1);
    chk("wr_rd1_r0", bus.read_data1, 8'd13);
    chk("wr_rd2_r1", bus.read_data2, 8'd25);

    // 3. With write_enable low, nothing changes.
    bus.write_enable = 1'b0;
    bus.write_reg    = 3'd2;
    bus.write_data   = 8'd99;
    step();
    rd(2, 2);
    chk("wr_disabled", bus.read_data1, 8'd0);

    // 4. No bypass: the read port returns the old value before the edge and the new one after it.
    rd(3, 0);
    bus.write_enable = 1'b1;
    bus.write_reg    = 3'd3;
    bus.write_data   = 8'd77;
    #1;
    chk("nobypass_before", bus.read_data1, 8'd0);
    step();
    bus.write_enable = 1'b0;
    chk("nobypass_after", bus.read_data1, 8'd77);

    // 5. Reset has priority over a write on the same edge.
    reset            = 1'b1;
    bus.write_enable = 1'b1;
    bus.write_reg    = 3'd4;
    bus.write_data   = 8'd55;
    step();
    reset            = 1'b0;
    bus.write_enable = 1'b0;
    rd(4, 0);
    chk("rst_prio_r4", bus.read_data1, 8'd0);
    chk("rst_prio_r0", bus.read_data2, 8'd0);

    // 6. Full sweep: write i*17 to each register, then read every address pair.
    for (int i = 0; i < NUM_REGS; i++) wr(i, i * 17);
    for (int a = 0; a < NUM_REGS; a++) begin
      for (int b = 0; b < NUM_REGS; b++) begin
        rd(a, b);
        chk("sweep_rd1", bus.read_data1, data_t'(a * 17));
        chk("sweep_rd2", bus.read_data2, data_t'(b * 17));
      end
    end

    // Randomized traffic checked against the model, before and after each edge.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      reset            = ($urandom_range(0, 19) == 0);
      bus.write_enable = $urandom_range(0, 1);
      bus.write_reg    = addr_t'($urandom_range(0, NUM_REGS - 1));
      bus.write_data   = data_t'($urandom_range(0, 255));
      rd($urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1));
      chk("rand_pre_rd1", bus.read_data1, data_t'(model[bus.read_reg1]));
      chk("rand_pre_rd2", bus.read_data2, data_t'(model[bus.read_reg2]));
      step();
      chk("rand_post_rd1", bus.read_data1, data_t'(model[bus.read_reg1]));
      chk("rand_post_rd2", bus.read_data2, data_t'(model[bus.read_reg2]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
